// File: rtl/result_transmitter_pkg.sv
// Shared calculator definitions: UART state enum, ASCII constants, message length.
// Latency: n/a (types and constants only).
// Backpressure: n/a. RESULT_TX_CRLF_EN selects a 6-byte message (CR LF appended), else 4 bytes.
package result_transmitter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } txState_t;

   localparam logic [7:0] ASCII_PLUS  = 8'h2B;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_QMARK = 8'h3F;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;

`ifdef RESULT_TX_CRLF_EN
   localparam int MSG_LEN = 6;
`else
   localparam int MSG_LEN = 4;
`endif

   // Byte index width; covers both message lengths.
   localparam int IDX_W = 3;

   // BCD digit to ASCII; non-decimal codes become '?'.
   function automatic logic [7:0] digitChar(input logic [3:0] d);
      return (d > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'd0, d});
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one byte as 8N1 UART (start, 8 data LSB first, stop), CLKS_PER_BIT cycles per bit.
// Latency: TxD goes low on the edge that accepts the byte; frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: byteReady high when idle or in the last cycle of the stop bit, so frames chain gap-free.
module uart_tx_byte
   import result_transmitter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byteValid,
   input  logic [7:0] byteData,
   output logic       byteReady,
   output logic       byteEnd,
   output logic       TxD
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   txState_t         state, stateNext;
   logic [CNT_W-1:0] bitCnt, bitCntNext;
   logic [2:0]       bitIdx, bitIdxNext;
   logic [7:0]       shiftReg, shiftNext;
   logic             txdReg, txdNext;
   logic             bitEnd;

   assign bitEnd    = (bitCnt == CNT_LAST);
   assign byteEnd   = (state == STOP) && bitEnd;
   assign byteReady = (state == IDLE) || byteEnd;
   assign TxD       = txdReg;

   // State and datapath registers; TxD is registered so it changes exactly on bit boundaries.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bitCnt   <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         txdReg   <= 1'b1;
      end else begin
         state    <= stateNext;
         bitCnt   <= bitCntNext;
         bitIdx   <= bitIdxNext;
         shiftReg <= shiftNext;
         txdReg   <= txdNext;
      end
   end

   // Next-state logic: bit counter wraps to 0 at each bit boundary; STOP may chain straight into START.
   always_comb begin
      stateNext  = state;
      bitCntNext = bitEnd ? '0 : bitCnt + 1'b1;
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      txdNext    = txdReg;
      case (state)
         IDLE: begin
            bitCntNext = '0;
            txdNext    = 1'b1;
            if (byteValid) begin
               stateNext = START;
               shiftNext = byteData;
               txdNext   = 1'b0;
            end
         end
         START: begin
            if (bitEnd) begin
               stateNext  = DATA;
               bitIdxNext = '0;
               txdNext    = shiftReg[0];
               shiftNext  = shiftReg >> 1;
            end
         end
         DATA: begin
            if (bitEnd) begin
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
                  txdNext   = 1'b1;
               end else begin
                  bitIdxNext = bitIdx + 1'b1;
                  txdNext    = shiftReg[0];
                  shiftNext  = shiftReg >> 1;
               end
            end
         end
         STOP: begin
            if (bitEnd) begin
               if (byteValid) begin
                  stateNext = START;
                  shiftNext = byteData;
                  txdNext   = 1'b0;
               end else begin
                  stateNext = IDLE;
                  txdNext   = 1'b1;
               end
            end
         end
         default: begin
            stateNext  = IDLE;
            bitCntNext = '0;
            txdNext    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/result_transmitter.sv
// Sends a signed 3-digit BCD result as ASCII over UART: sign, hundreds, tens, ones (+ CR LF with RESULT_TX_CRLF_EN).
// Latency: start bit on the accepting edge; done pulses on the edge ending the last stop bit.
// Backpressure: start is ignored (not queued) while busy; inputs are captured on acceptance.
module result_transmitter
   import result_transmitter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       sign,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic       TxD,
   output logic       busy,
   output logic       done
);

   logic             busyReg, doneReg;
   logic [3:0]       hundCap, tensCap, onesCap;
   logic [IDX_W-1:0] byteIdx, nextIdx;
   logic             byteValid, byteReady, byteEnd;
   logic [7:0]       byteData;
   logic             accept, lastByte;

   assign accept    = !busyReg && start && byteReady;
   assign lastByte  = (byteIdx == IDX_W'(MSG_LEN - 1));
   assign byteValid = accept || (busyReg && byteEnd && !lastByte);
   assign busy      = busyReg;
   assign done      = doneReg;

   // Byte to hand to the serialiser: the sign byte comes straight from the inputs on acceptance,
   // later bytes come from the captured digits.
   always_comb begin
      nextIdx  = byteIdx + 1'b1;
      byteData = ASCII_QMARK;
      if (!busyReg) begin
         byteData = sign ? ASCII_MINUS : ASCII_PLUS;
      end else begin
         case (nextIdx)
            3'd1:    byteData = digitChar(hundCap);
            3'd2:    byteData = digitChar(tensCap);
            3'd3:    byteData = digitChar(onesCap);
`ifdef RESULT_TX_CRLF_EN
            3'd4:    byteData = ASCII_CR;
            3'd5:    byteData = ASCII_LF;
`endif
            default: byteData = ASCII_QMARK;
         endcase
      end
   end

   // Message sequencing: capture on accept, advance per completed byte, done on the final stop bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         busyReg <= 1'b0;
         doneReg <= 1'b0;
         hundCap <= '0;
         tensCap <= '0;
         onesCap <= '0;
         byteIdx <= '0;
      end else begin
         doneReg <= 1'b0;
         if (accept) begin
            busyReg <= 1'b1;
            hundCap <= hundreds;
            tensCap <= tens;
            onesCap <= ones;
            byteIdx <= '0;
         end else if (busyReg && byteEnd) begin
            if (lastByte) begin
               busyReg <= 1'b0;
               doneReg <= 1'b1;
            end else begin
               byteIdx <= nextIdx;
            end
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uTxByte (
      .clk      (clk),
      .reset    (reset),
      .byteValid(byteValid),
      .byteData (byteData),
      .byteReady(byteReady),
      .byteEnd  (byteEnd),
      .TxD      (TxD)
   );

endmodule

// File: tb/tb_result_transmitter.sv
// Scoreboard bench for result_transmitter at CLKS_PER_BIT=4.
// Stimulus pushes expected bytes; a UART monitor decodes TxD and pops/compares.
// Also checks bit framing, gap-free bytes, done timing/count, reset behaviour.
module tb_result_transmitter;

   localparam int CPB        = 4;
   localparam int BYTE_CYC   = 10 * CPB;
   localparam int MSG_BUDGET = 8 * BYTE_CYC;

   logic       clk = 1'b0;
   logic       reset, start, sign;
   logic [3:0] hundreds, tens, ones;
   logic       TxD, busy, done;

   result_transmitter #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .sign    (sign),
      .hundreds(hundreds),
      .tens    (tens),
      .ones    (ones),
      .TxD     (TxD),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] expQ[$];      // {first byte of message, byte}
   int         doneCount = 0;
   int         expDone = 0;
   int         cyc = 0;
   logic       rxActive = 1'b0;
   int         rxCnt = 0;
   logic [7:0] rxByte = '0;
   int         lastStartCyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // UART monitor and done watcher, sampled on the falling edge.
   always @(negedge clk) begin
      logic [8:0] e;
      int         k;
      cyc++;
      if (done) begin
         doneCount++;
         check("done_timing", cyc - lastStartCyc, BYTE_CYC);
         check("busy_at_done", busy, 0);
      end
      if (reset) begin
         rxActive = 1'b0;
      end else if (!rxActive) begin
         if (TxD == 1'b0) begin
            rxActive = 1'b1;
            rxCnt    = 0;
            if (expQ.size() > 0 && !expQ[0][8])
               check("byte_gap", cyc - lastStartCyc, BYTE_CYC);
            lastStartCyc = cyc;
         end
      end else begin
         rxCnt++;
         if (rxCnt == CPB / 2) begin
            check("start_bit", TxD, 0);
         end else if (rxCnt > CPB / 2 && ((rxCnt - CPB / 2) % CPB) == 0) begin
            k = (rxCnt - CPB / 2) / CPB;
            if (k <= 8) begin
               rxByte[k-1] = TxD;
            end else begin
               check("stop_bit", TxD, 1);
               check("busy_in_msg", busy, 1);
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_byte: got %0h expected none", rxByte);
               end else begin
                  e = expQ.pop_front();
                  check("byte", rxByte, e[7:0]);
               end
               rxActive = 1'b0;
            end
         end
      end
   end

   task automatic startMsg(input logic s, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] e3);
      expQ.push_back({1'b1, e0});
      expQ.push_back({1'b0, e1});
      expQ.push_back({1'b0, e2});
      expQ.push_back({1'b0, e3});
`ifdef RESULT_TX_CRLF_EN
      expQ.push_back({1'b0, 8'h0D});
      expQ.push_back({1'b0, 8'h0A});
`endif
      @(negedge clk);
      sign = s; hundreds = h; tens = t; ones = o; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_on_accept", busy, 1);
      check("txd_start_on_accept", TxD, 0);
      expDone++;
   endtask

   task automatic finishMsg();
      int n = 0;
      while (!done && n < MSG_BUDGET) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", MSG_BUDGET);
      end
      @(negedge clk);
      check("done_pulse_width", done, 0);
      check("done_count", doneCount, expDone);
      check("queue_empty", expQ.size(), 0);
      check("idle_txd", TxD, 1);
      check("busy_clear", busy, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sign = 1'b0;
      hundreds = '0; tens = '0; ones = '0;
      repeat (3) @(negedge clk);
      check("reset_txd", TxD, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      reset = 1'b0;
      @(negedge clk);

      startMsg(1'b0, 4'd1, 4'd2, 4'd3, 8'h2B, 8'h31, 8'h32, 8'h33);
      finishMsg();
      startMsg(1'b1, 4'd0, 4'd0, 4'd7, 8'h2D, 8'h30, 8'h30, 8'h37);
      finishMsg();
      startMsg(1'b0, 4'd12, 4'd3, 4'd4, 8'h2B, 8'h3F, 8'h33, 8'h34);
      finishMsg();
      startMsg(1'b1, 4'd5, 4'd10, 4'd15, 8'h2D, 8'h35, 8'h3F, 8'h3F);
      finishMsg();

      // Second start and changed inputs while busy: message unchanged, one done.
      startMsg(1'b0, 4'd9, 4'd8, 4'd7, 8'h2B, 8'h39, 8'h38, 8'h37);
      repeat (BYTE_CYC + 7) @(negedge clk);
      sign = 1'b1; hundreds = 4'd1; tens = 4'd1; ones = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; hundreds = 4'd2;
      finishMsg();

      // Reset during byte 2: abort, no done, then a clean message.
      startMsg(1'b1, 4'd3, 4'd4, 4'd5, 8'h2D, 8'h33, 8'h34, 8'h35);
      repeat (BYTE_CYC + 15) @(negedge clk);
      reset = 1'b1;
      expQ.delete();
      expDone--;
      @(negedge clk);
      check("abort_txd", TxD, 1);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (BYTE_CYC) @(negedge clk);
      check("abort_no_done", doneCount, expDone);
      startMsg(1'b0, 4'd4, 4'd5, 4'd6, 8'h2B, 8'h34, 8'h35, 8'h36);
      finishMsg();

      // Reset and start on the same edge: reset wins.
      @(negedge clk);
      reset = 1'b1; start = 1'b1; sign = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rst_prio_busy", busy, 0);
      check("rst_prio_txd", TxD, 1);
      @(negedge clk);
      reset = 1'b0;
      repeat (BYTE_CYC) @(negedge clk);
      check("rst_prio_no_done", doneCount, expDone);
      check("rst_prio_idle", TxD, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/result_transmitter.md
RESULT_TRANSMITTER -- requirements
Module: result_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, meaning clk cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port start  input  1  request to transmit one result message.
REQ-005 SHALL have port sign  input  1  result sign, 1 = negative.
REQ-006 SHALL have port hundreds  input  4  BCD hundreds digit.
REQ-007 SHALL have port tens  input  4  BCD tens digit.
REQ-008 SHALL have port ones  input  4  BCD ones digit.
REQ-009 SHALL have port TxD  output  1  UART serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a message is in progress.
REQ-011 SHALL have port done  output  1  single-cycle pulse at message end.

Function
REQ-012 SHALL accept start only when busy=0; start while busy=1 is ignored, with no queueing.
REQ-013 SHALL capture sign, hundreds, tens, ones on the accepting edge; later input changes do not affect the message.
REQ-014 SHALL set busy=1 on the edge that accepts start; TxD SHALL drop low (start bit) on that same edge.
REQ-015 SHALL send bytes in order:
- sign char: '-' 0x2D if sign=1, '+' 0x2B otherwise;
- hundreds, tens, ones, each as 0x30+digit;
- any digit value 10..15 SHALL be sent as '?' 0x3F.
REQ-016 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-017 SHALL start consecutive bytes back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
REQ-018 SHALL use states IDLE -> START -> DATA (8 bits) -> STOP, then START again if bytes remain, else IDLE.
REQ-019 SHALL clear busy and pulse done=1 for one cycle on the edge ending the final stop bit; start may be accepted on the next edge.
REQ-020 SHALL hold TxD=1 in IDLE.
REQ-021 SHALL size the bit counter to hold CLKS_PER_BIT-1 without overflow, and return it to 0 at each bit boundary.

Reset
REQ-022 SHALL drive TxD=1, busy=0, done=0 and state IDLE, and clear all counters and captured data, on the first edge with reset=1.
REQ-023 SHALL abort any in-progress message on reset, with no done pulse.
REQ-024 SHALL, when reset and start are high on the same edge, give reset priority and ignore start.

Configuration
REQ-025 SHALL, with macro RESULT_TX_CRLF_EN defined, append CR 0x0D then LF 0x0A, for a 6-byte message.
REQ-026 SHALL, without RESULT_TX_CRLF_EN, send a 4-byte message; all other behaviour is identical.

Structure
REQ-027 SHALL take the state enum, the ASCII constants ('+', '-', '0', '?', CR, LF) and the message-length constant from the shared calculator package.
REQ-028 SHALL instantiate one sub-module, uart_tx_byte, which serialises one byte with a valid/ready handshake. result_transmitter sequences the bytes.

Verification (CLKS_PER_BIT=4)
REQ-029 SHALL cover: reset, then start with sign=0, digits 1,2,3 -> TxD bytes 0x2B 0x31 0x32 0x33; each bit 4 cycles; done one cycle at end; busy high throughout.
REQ-030 SHALL cover: sign=1, digits 0,0,7 -> bytes 0x2D 0x30 0x30 0x37, LSB-first, no inter-byte gap.
REQ-031 SHALL cover: hundreds=12 -> second byte 0x3F.
REQ-032 SHALL cover: second start pulse mid-message, plus digit inputs changed mid-message -> message unchanged, exactly one done.
REQ-033 SHALL cover: reset asserted during byte 2 -> TxD=1 and busy=0 next edge, no done; a new start afterwards produces a full, correct message.
REQ-034 SHALL cover: RESULT_TX_CRLF_EN defined, digits 4,5,6 -> 0x2B 0x34 0x35 0x36 0x0D 0x0A, done after the LF stop bit (60 bit times total).
